elastic_pipe: RTL and testbench

//  Parametrised valid/ready pipeline: STAGES register slices of W-bit data between router FIFO/arbiter boundaries.

---
 rtl/elastic_pipe.sv | 90 +++++++++
 tb/tb_elastic_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe.sv
// elastic_pipe: valid/ready register-slice pipeline with skid buffering, flush and occupancy count
module elastic_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int MODE   = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [W-1:0]                    in_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [W-1:0]                    out_data_o,
  output logic [$clog2(2*STAGES+2)-1:0]   occ_o
);
  localparam int OW = $clog2(2*STAGES+2);
  logic            blk, in_fire, out_fire;
  logic [STAGES:0] v, r;
  logic [W-1:0]    d [STAGES+1];
  logic [OW-1:0]   occ_q, occ_d;
  // reset and flush both freeze both handshakes; a pass-through pipe has nothing to flush
  assign blk         = rst_i | ((STAGES > 0) && flush_i);
  assign v[0]        = in_valid_i & ~blk;
  assign d[0]        = in_data_i;
  assign r[STAGES]   = out_ready_i & ~blk;
  assign in_ready_o  = r[0] & ~blk;
  assign out_valid_o = v[STAGES] & ~blk;
  assign out_data_o  = rst_i ? '0 : d[STAGES];
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign occ_d       = occ_q + OW'(in_fire) - OW'(out_fire);
  assign occ_o       = occ_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) occ_q <= '0;
    else occ_q <= flush_i ? '0 : occ_d;
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (MODE == 0) begin : g_fwd
      logic v_q, v_d;
      logic [W-1:0] d_q, d_d;
      // ready looks through every downstream stage at once, so no chained loop on r
      assign r[k]   = r[STAGES] | ~&v[STAGES:k+1];
      assign v[k+1] = v_q;
      assign d[k+1] = d_q;
      always_comb begin
        v_d = r[k] ? v[k] : v_q;
        d_d = (v[k] & r[k]) ? d[k] : d_q;
      end
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= v_d & ~flush_i;
          d_q <= d_d;
        end
      end
    end else begin : g_full
      logic mv_q, mv_d, sv_q, sv_d, acc, pop;
      logic [W-1:0] md_q, md_d, sd_q, sd_d;
      assign acc    = v[k] & ~sv_q;
      assign pop    = mv_q & r[k+1];
      assign r[k]   = ~sv_q;
      assign v[k+1] = mv_q;
      assign d[k+1] = md_q;
      // skid only fills while main is stuck; it drains into main before new input is taken
      always_comb begin
        mv_d = sv_q | acc | (mv_q & ~pop);
        sv_d = sv_q ? ~pop : (acc & mv_q & ~pop);
        md_d = (sv_q & pop) ? sd_q : (acc & (~mv_q | pop)) ? d[k] : md_q;
        sd_d = (acc & mv_q & ~pop) ? d[k] : sd_q;
      end
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          mv_q <= 1'b0;
          sv_q <= 1'b0;
          md_q <= '0;
          sd_q <= '0;
        end else begin
          mv_q <= mv_d & ~flush_i;
          sv_q <= sv_d & ~flush_i;
          md_q <= md_d;
          sd_q <= sd_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: random and directed stimulus on full-slice, forward-slice and pass-through pipes,
// checked by a queue-based FIFO model and a negedge monitor.
module tb_elastic_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, flush = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [7:0] id = 8'h00;
  logic ir0, ov0, ir1, ov1;
  logic [7:0] od0, od1;
  logic [2:0] oc0, oc1;
  logic ziv = 1'b0, zor = 1'b0, zir, zov;
  logic [7:0] zid = 8'h00, zod;
  logic [0:0] zoc;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic rst_p = 1'b0, lat_exact = 1'b0;
  logic [7:0] sq [2][$];
  int tq [2][$];
  logic stall_p [2];
  logic [7:0] od_p [2];
  int acc [2], outc [2];
  int a0, a1, o0, o1;

  elastic_pipe #(.W(8), .STAGES(2), .MODE(1)) u_m1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(ir0), .in_data_i(id),
    .out_valid_o(ov0), .out_ready_i(ordy), .out_data_o(od0), .occ_o(oc0));
  elastic_pipe #(.W(8), .STAGES(2), .MODE(0)) u_m0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(ir1), .in_data_i(id),
    .out_valid_o(ov1), .out_ready_i(ordy), .out_data_o(od1), .occ_o(oc1));
  elastic_pipe #(.W(8), .STAGES(0), .MODE(1)) u_z (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(ziv), .in_ready_o(zir), .in_data_i(zid),
    .out_valid_o(zov), .out_ready_i(zor), .out_data_o(zod), .occ_o(zoc));

  function automatic void chk(string n, int a, int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  task automatic mon(int i, int cap, logic irs, logic ovs, logic [7:0] ods, logic [2:0] ocs);
    int lat;
    if (rst) begin
      chk($sformatf("rst_in_ready%0d", i), int'(irs), 0);
      chk($sformatf("rst_out_valid%0d", i), int'(ovs), 0);
      chk($sformatf("rst_out_data%0d", i), int'(ods), 0);
      if (rst_p) chk($sformatf("rst_occ%0d", i), int'(ocs), 0);
      sq[i].delete(); tq[i].delete(); stall_p[i] = 1'b0;
      return;
    end
    chk($sformatf("occ%0d", i), int'(ocs), sq[i].size());
    chk($sformatf("occ_cap%0d", i), int'(int'(ocs) <= cap), 1);
    if (flush) begin
      chk($sformatf("flush_in_ready%0d", i), int'(irs), 0);
      chk($sformatf("flush_out_valid%0d", i), int'(ovs), 0);
      sq[i].delete(); tq[i].delete(); stall_p[i] = 1'b0;
      return;
    end
    if (stall_p[i]) begin
      chk($sformatf("hold_valid%0d", i), int'(ovs), 1);
      chk($sformatf("hold_data%0d", i), int'(ods), int'(od_p[i]));
    end
    if (ovs && ordy) begin
      if (sq[i].size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_out%0d: got data %0d with no word expected (cycle %0d)", i, ods, cyc);
      end else begin
        chk($sformatf("out_data%0d", i), int'(ods), int'(sq[i].pop_front()));
        lat = cyc - tq[i].pop_front();
        if (lat_exact) chk($sformatf("latency%0d", i), lat, 2);
        else if (lat < 2) chk($sformatf("min_latency%0d", i), lat, 2);
        outc[i]++;
      end
    end
    if (int'(ocs) == cap && !ordy) chk($sformatf("full_in_ready%0d", i), int'(irs), 0);
    if (iv && irs) begin
      sq[i].push_back(id); tq[i].push_back(cyc); acc[i]++;
    end
    stall_p[i] = ovs && !ordy;
    od_p[i] = ods;
  endtask

  always @(negedge clk) begin
    mon(0, 4, ir0, ov0, od0, oc0);
    mon(1, 2, ir1, ov1, od1, oc1);
    rst_p = rst;
    cyc++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      stall_p[i] = 1'b0; od_p[i] = 8'h00; acc[i] = 0; outc[i] = 0;
    end
    iv = 1'b1; id = 8'hA5;
    repeat (3) step;
    rst = 1'b0; iv = 1'b0;
    step;
    // back-to-back stream with an always-ready sink
    a0 = acc[0]; a1 = acc[1]; o0 = outc[0]; o1 = outc[1];
    lat_exact = 1'b1; ordy = 1'b1; iv = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      id = 8'(k);
      step;
    end
    iv = 1'b0;
    repeat (4) step;
    lat_exact = 1'b0;
    chk("stream_acc_m1", acc[0] - a0, 16);
    chk("stream_acc_m0", acc[1] - a1, 16);
    chk("stream_out_m1", outc[0] - o0, 16);
    chk("stream_out_m0", outc[1] - o1, 16);
    // backpressure fill
    a0 = acc[0]; a1 = acc[1]; o0 = outc[0]; o1 = outc[1];
    ordy = 1'b0; iv = 1'b1;
    repeat (8) begin
      id = 8'(1 + acc[0] - a0);
      step;
    end
    chk("bp_acc_m1", acc[0] - a0, 4);
    chk("bp_acc_m0", acc[1] - a1, 2);
    chk("bp_occ_m1", int'(oc0), 4);
    chk("bp_occ_m0", int'(oc1), 2);
    chk("bp_data_m1", int'(od0), 1);
    chk("bp_data_m0", int'(od1), 1);
    chk("bp_ready_m1", int'(ir0), 0);
    chk("bp_ready_m0", int'(ir1), 0);
    iv = 1'b0; ordy = 1'b1;
    repeat (6) step;
    chk("bp_drain_m1", outc[0] - o0, 4);
    chk("bp_drain_m0", outc[1] - o1, 2);
    // random valid/ready at 50%
    a0 = acc[0]; a1 = acc[1];
    for (int n = 0; n < 20000 && (acc[0] - a0 < 1000 || acc[1] - a1 < 1000); n++) begin
      iv = 1'($urandom % 2); ordy = 1'($urandom % 2); id = 8'($urandom);
      step;
    end
    chk("rand_words_m1", int'(acc[0] - a0 >= 1000), 1);
    chk("rand_words_m0", int'(acc[1] - a1 >= 1000), 1);
    iv = 1'b0; ordy = 1'b1;
    repeat (6) step;
    chk("rand_left_m1", sq[0].size(), 0);
    chk("rand_left_m0", sq[1].size(), 0);
    // reset mid-stream: nothing held may come out afterwards
    ordy = 1'b0; iv = 1'b1; id = 8'h5A;
    repeat (3) step;
    rst = 1'b1;
    repeat (2) step;
    rst = 1'b0; iv = 1'b0; ordy = 1'b1;
    o0 = outc[0]; o1 = outc[1];
    repeat (5) step;
    chk("post_rst_out_m1", outc[0] - o0, 0);
    chk("post_rst_out_m0", outc[1] - o1, 0);
    // flush with three words held
    ordy = 1'b0; iv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id = 8'(8'h50 + k);
      step;
    end
    chk("pre_flush_occ_m1", int'(oc0), 3);
    chk("pre_flush_occ_m0", int'(oc1), 2);
    flush = 1'b1; id = 8'h66;
    step;
    flush = 1'b0; iv = 1'b0;
    chk("flush_occ_m1", int'(oc0), 0);
    chk("flush_occ_m0", int'(oc1), 0);
    chk("flush_ov_m1", int'(ov0), 0);
    chk("flush_ov_m0", int'(ov1), 0);
    o0 = outc[0]; o1 = outc[1];
    ordy = 1'b1; iv = 1'b1; id = 8'h77;
    step;
    iv = 1'b0;
    repeat (4) step;
    chk("post_flush_out_m1", outc[0] - o0, 1);
    chk("post_flush_out_m0", outc[1] - o1, 1);
    // pass-through pipe, flush must be ignored
    ziv = 1'b1; zid = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      zor = (i % 2 == 0);
      flush = (i == 3);
      #2;
      chk("z_data", int'(zod), 8'h3C);
      chk("z_valid", int'(zov), 1);
      chk("z_ready", int'(zir), int'(zor));
      chk("z_occ", int'(zoc), 0);
      step;
    end
    flush = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
